// File: rtl/mcycle_sched.sv
// Multi-cycle multiply/divide scheduler: accepts one operation at a time, sequences the
// iterative engine, and arbitrates the shared register-file write port against Writeback.
module mcycle_sched #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        StartE,
  input  logic        OpE,
  input  logic        SignedE,
  input  logic [3:0]  WA3E,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [31:0] EngResult,
  output logic        EngStart,
  output logic        EngStep,
  output logic        EngOp,
  output logic        EngSigned,
  output logic        M_StartE,
  output logic        M_BusyE,
  output logic        M_DoneE,
  output logic        M_StallE,
  output logic [3:0]  WA3R,
  output logic        WE3R,
  output logic [31:0] WD3R
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [3:0]  wa3_q;
  logic [31:0] wd3_q;
  logic        op_q;
  logic        sgn_q;

  logic req;
  logic wb_free;
  logic accept;

  // Gating with RESETn keeps every output low while reset is held, including the
  // purely combinational request paths.
  assign req     = RESETn & StartE & ~FlushE;
  assign wb_free = (state_q == S_DONE) & ~RegWriteW;
  assign accept  = req & ((state_q == S_IDLE) | wb_free);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wa3_q   <= '0;
      wd3_q   <= '0;
      op_q    <= 1'b0;
      sgn_q   <= 1'b0;
    end else if (accept) begin
      state_q <= S_BUSY;
      cnt_q   <= OpE ? DIV_LOAD : MUL_LOAD;
      wa3_q   <= WA3E;
      op_q    <= OpE;
      sgn_q   <= SignedE;
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_IDLE;
        S_BUSY: begin
          if (cnt_q == '0) begin
            wd3_q   <= EngResult;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        S_DONE: if (wb_free) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign EngStart  = accept;
  assign M_StartE  = accept;
  assign M_StallE  = req & ~accept;
  assign EngStep   = (state_q == S_BUSY);
  assign WE3R      = wb_free;
  assign M_DoneE   = wb_free;
  assign M_BusyE   = (state_q == S_BUSY) | ((state_q == S_DONE) & (RegWriteW | accept));
  assign EngOp     = op_q;
  assign EngSigned = sgn_q;
  assign WA3R      = wa3_q;
  assign WD3R      = wd3_q;

endmodule

// File: tb/tb_mcycle_sched.sv
// Directed and random checks of mcycle_sched against a transaction-level model that
// tracks the single outstanding operation by its accept cycle and result-ready cycle.
module tb_mcycle_sched;

  localparam int MULC = 4;
  localparam int DIVC = 32;

  logic        CLK;
  logic        RESETn;
  logic        StartE, OpE, SignedE, FlushE, RegWriteW;
  logic [3:0]  WA3E;
  logic [31:0] EngResult;
  logic        EngStart, EngStep, EngOp, EngSigned;
  logic        M_StartE, M_BusyE, M_DoneE, M_StallE;
  logic [3:0]  WA3R;
  logic        WE3R;
  logic [31:0] WD3R;

  int errors = 0;
  int checks = 0;

  mcycle_sched #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .CLK(CLK), .RESETn(RESETn), .StartE(StartE), .OpE(OpE), .SignedE(SignedE),
    .WA3E(WA3E), .FlushE(FlushE), .RegWriteW(RegWriteW), .EngResult(EngResult),
    .EngStart(EngStart), .EngStep(EngStep), .EngOp(EngOp), .EngSigned(EngSigned),
    .M_StartE(M_StartE), .M_BusyE(M_BusyE), .M_DoneE(M_DoneE), .M_StallE(M_StallE),
    .WA3R(WA3R), .WE3R(WE3R), .WD3R(WD3R)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: at most one operation; result is ready (pending write) from cycle m_ready on.
  bit          m_have;
  int          m_ready;
  int          m_c;
  logic [3:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_op, m_sgn;
  logic        m_we, m_acc, m_stall, m_eng, m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, m_c);
    end
  endtask

  task automatic drive(input logic rst, input logic start, input logic op, input logic sgn,
                       input logic [3:0] wa, input logic flush, input logic rw,
                       input logic [31:0] res);
    @(negedge CLK);
    RESETn = rst; StartE = start; OpE = op; SignedE = sgn; WA3E = wa;
    FlushE = flush; RegWriteW = rw; EngResult = res;
    #2;
    if (!rst) begin
      m_have = 0; m_wa = '0; m_wd = '0; m_op = 0; m_sgn = 0;
    end
    m_eng   = m_have && (m_c < m_ready);
    m_we    = m_have && (m_c >= m_ready) && !rw;
    m_acc   = rst && start && !flush && (!m_have || m_we);
    m_stall = rst && start && !flush && !m_acc;
    m_busy  = (m_have && !m_we) || (m_we && m_acc);
    chk("M_StartE", M_StartE, m_acc);
    chk("EngStart", EngStart, m_acc);
    chk("M_StallE", M_StallE, m_stall);
    chk("EngStep", EngStep, m_eng);
    chk("WE3R", WE3R, m_we);
    chk("M_DoneE", M_DoneE, m_we);
    chk("M_BusyE", M_BusyE, m_busy);
    chk("WA3R", WA3R, m_wa);
    chk("WD3R", WD3R, m_wd);
    chk("EngOp", EngOp, m_op);
    chk("EngSigned", EngSigned, m_sgn);
  endtask

  task automatic advance();
    if (RESETn) begin
      if (m_eng && m_c == m_ready - 1) m_wd = EngResult;
      if (m_we) m_have = 0;
      if (m_acc) begin
        m_have  = 1;
        m_ready = m_c + (OpE ? DIVC : MULC) + 1;
        m_wa    = WA3E;
        m_op    = OpE;
        m_sgn   = SignedE;
      end
    end
    m_c++;
    @(posedge CLK);
  endtask

  task automatic idle(input int n, input logic [31:0] res);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 4'd0, 0, 0, res);
      advance();
    end
  endtask

  initial begin
    RESETn = 0; StartE = 0; OpE = 0; SignedE = 0; WA3E = '0; FlushE = 0;
    RegWriteW = 0; EngResult = '0;
    m_have = 0; m_ready = 0; m_c = 0; m_wa = '0; m_wd = '0; m_op = 0; m_sgn = 0;

    // Reset state, with a request present that must be ignored.
    drive(0, 1, 1, 1, 4'hF, 0, 0, 32'hFFFF_FFFF);
    chk("rst_WD3R", WD3R, 32'h0);
    advance();
    drive(0, 0, 0, 0, 4'd0, 0, 0, 0); advance();
    idle(2, 0);

    // Multiply latency: accept at t, steps t+1..t+4, write at t+5.
    drive(1, 1, 0, 1, 4'd5, 0, 0, 0);
    chk("mul_accept", M_StartE, 1'b1);
    advance();
    for (int i = 1; i <= MULC; i++) begin
      drive(1, 0, 0, 0, 4'd0, 0, 0, 32'h30);
      chk("mul_step", EngStep, 1'b1);
      advance();
    end
    drive(1, 0, 0, 0, 4'd0, 0, 0, 32'h30);
    chk("mul_we", WE3R, 1'b1);
    chk("mul_wa", WA3R, 4'd5);
    chk("mul_wd", WD3R, 32'h30);
    chk("mul_done", M_DoneE, 1'b1);
    advance();
    drive(1, 0, 0, 0, 4'd0, 0, 0, 0);
    chk("mul_we_once", WE3R, 1'b0);
    advance();

    // Divide with writeback back-pressure for three cycles.
    drive(1, 1, 1, 0, 4'd9, 0, 0, 0); advance();
    for (int i = 1; i <= DIVC; i++) begin
      drive(1, 0, 0, 0, 4'd0, 0, 0, 32'hDEAD_BEEF);
      chk("div_busy", M_BusyE, 1'b1);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 4'd0, 0, 1, 32'h0);
      chk("div_hold_we", WE3R, 1'b0);
      chk("div_hold_busy", M_BusyE, 1'b1);
      advance();
    end
    drive(1, 0, 0, 0, 4'd0, 0, 0, 32'h0);
    chk("div_we", WE3R, 1'b1);
    chk("div_wd", WD3R, 32'hDEAD_BEEF);
    chk("div_wa", WA3R, 4'd9);
    advance();
    idle(1, 0);

    // Busy conflict, then re-presented request taken in the writeback cycle.
    drive(1, 1, 0, 0, 4'd3, 0, 0, 0); advance();
    idle(1, 32'h11);
    drive(1, 1, 0, 0, 4'd7, 0, 0, 32'h11);
    chk("conf_stall", M_StallE, 1'b1);
    chk("conf_nostart", EngStart, 1'b0);
    advance();
    drive(1, 0, 0, 0, 4'd0, 0, 0, 32'h11);
    chk("conf_wa_held", WA3R, 4'd3);
    advance();
    idle(1, 32'h11);
    drive(1, 1, 0, 1, 4'd7, 0, 0, 32'h0);
    chk("conf_we", WE3R, 1'b1);
    chk("conf_start", EngStart, 1'b1);
    chk("conf_wd", WD3R, 32'h11);
    advance();
    idle(MULC + 2, 32'h22);

    // Flushed request in IDLE is ignored.
    drive(1, 1, 1, 1, 4'd2, 1, 0, 0);
    chk("fl_start", M_StartE, 1'b0);
    chk("fl_stall", M_StallE, 1'b0);
    advance();
    drive(1, 0, 0, 0, 4'd0, 0, 0, 0);
    chk("fl_step", EngStep, 1'b0);
    chk("fl_busy", M_BusyE, 1'b0);
    advance();

    // Reset mid-divide discards the operation.
    drive(1, 1, 1, 1, 4'd12, 0, 0, 0); advance();
    idle(9, 32'h55);
    drive(0, 1, 0, 0, 4'd6, 0, 0, 32'h55);
    chk("rm_step", EngStep, 1'b0);
    chk("rm_busy", M_BusyE, 1'b0);
    chk("rm_wa", WA3R, 4'd0);
    chk("rm_start", EngStart, 1'b0);
    advance();
    drive(0, 0, 0, 0, 4'd0, 0, 0, 0); advance();
    for (int i = 0; i < DIVC + 4; i++) begin
      drive(1, 0, 0, 0, 4'd0, 0, 0, 32'h55);
      chk("rm_no_we", WE3R, 1'b0);
      advance();
    end
    drive(1, 1, 0, 0, 4'd4, 0, 0, 0); advance();
    idle(MULC, 32'h77);
    drive(1, 0, 0, 0, 4'd0, 0, 0, 0);
    chk("rm_new_we", WE3R, 1'b1);
    chk("rm_new_wa", WA3R, 4'd4);
    chk("rm_new_wd", WD3R, 32'h77);
    advance();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1, ($urandom_range(0, 9) < 4), $urandom_range(0, 3) == 0, 1'($urandom),
            4'($urandom), ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) < 3),
            $urandom);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
